msrv32_immediate_adder: RTL and testbench
=========================================

# msrv32_immediate_adder

Computes jump, branch and load/store target addresses for the msrv32 core by adding the sign-extended immediate to either the current PC or rs1. It sits between the decode/immediate-generator stage and the PC-mux and load/store unit. The primary sum is combinational; a registered copy and an alignment flag are also provided for the next pipeline stage.

## Interface
Parameters: none.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset.
- pc_in  input  32  current program counter.
- rs1_in  input  32  register-file source 1 value.
- imm_in  input  32  sign-extended immediate from the immediate generator.
- iadder_src_in  input  1  operand select: 0 selects pc_in, 1 selects rs1_in.
- iadder_out  output  32  combinational target address.
- iadder_q_out  output  32  iadder_out registered on the clock.
- iadder_src_q_out  output  1  iadder_src_in registered on the clock.
- misaligned_out  output  1  combinational flag: target is not 4-byte aligned.

## Operation
- Base is pc_in when iadder_src_in = 0, and rs1_in when iadder_src_in = 1.
- iadder_out = (base + imm_in) mod 2^32.
  - Unsigned 32-bit add. Carry out is discarded and no overflow flag exists.
  - Wrap-around is legal: 0xFFFFFFFC + 0x8 = 0x00000004.
- Signed offsets need no special handling. A negative imm_in arrives two's-complement sign-extended, so plain addition is correct.
- misaligned_out = iadder_out[1]. It is evaluated after the optional LSB clear (see Configuration).
- iadder_out and misaligned_out are purely combinational:
  - They settle within the same delta or cycle as any input change.
  - They do not depend on clock or reset.
- Registered stage:
  - On each rising clock edge, iadder_q_out <= iadder_out and iadder_src_q_out <= iadder_src_in.
  - There is no enable; the registers load every cycle.

## Timing
- iadder_out and misaligned_out: 0-cycle latency, no handshake.
- iadder_q_out and iadder_src_q_out: 1-cycle latency.
- Reset values: iadder_q_out = 0x00000000, iadder_src_q_out = 0. Combinational outputs have no reset value.
- Reset assertion clears the registers immediately, without waiting for a clock edge, including in the middle of operation.
  - While reset is held, the registers stay at their reset values.
  - iadder_out keeps tracking its inputs.
  - The first capture after reset happens on the first rising edge after deassertion.
- Simultaneous input change and clock edge: the register captures the value settled before the edge (standard setup semantics).

## Configuration
- Macro: MSRV32_IADDER_JALR_LSB_CLR_EN.
- Defined: when iadder_src_in = 1, bit 0 of iadder_out is forced to 0 (RISC-V JALR semantics). This also affects the registered copy and misaligned_out. With iadder_src_in = 0 the sum is unmodified.
- Undefined: iadder_out is the raw sum in all cases.

## Test plan
- pc_in=0x12345678, imm_in=0xABCDEF01, iadder_src_in=0 -> iadder_out=0xBE024579 immediately, misaligned_out=0. After one clock edge, iadder_q_out=0xBE024579.
- rs1_in=0x87654321, imm_in=0x98765432, iadder_src_in=1 -> carry discarded.
  - Macro undefined: iadder_out=0x1FDB9753.
  - Macro defined: iadder_out=0x1FDB9752.
- pc_in=0xFFFFFFFC, imm_in=0x00000008, src=0 -> iadder_out=0x00000004 (wrap-around).
- pc_in=0x00001000, imm_in=0xFFFFFFFE (-2), src=0 -> iadder_out=0x00000FFE, misaligned_out=1.
- Run with nonzero registered values, then assert reset between clock edges -> iadder_q_out=0 and iadder_src_q_out=0 at once, while iadder_out still reflects its inputs. Deassert reset, then clock once -> registers load the current iadder_out.
- Toggle iadder_src_in with pc_in != rs1_in and imm_in fixed -> iadder_out switches between the two sums in the same cycle, and iadder_src_q_out follows one cycle later.

Source files
------------

// File: rtl/msrv32_immediate_adder.sv
// Target-address adder: adds the immediate to PC or rs1 and keeps a registered copy.
// Optional JALR LSB clear is enabled by defining MSRV32_IADDER_JALR_LSB_CLR_EN.
module msrv32_immediate_adder (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] imm_in,
    input  logic        iadder_src_in,
    output logic [31:0] iadder_out,
    output logic [31:0] iadder_q_out,
    output logic        iadder_src_q_out,
    output logic        misaligned_out
);

    logic [31:0] base;
    logic [31:0] sum;

    always_comb begin
        base = iadder_src_in ? rs1_in : pc_in;
        sum  = base + imm_in;
`ifdef MSRV32_IADDER_JALR_LSB_CLR_EN
        // JALR targets drop bit 0; PC-relative targets are left untouched.
        if (iadder_src_in)
            sum[0] = 1'b0;
`endif
    end

    assign iadder_out     = sum;
    assign misaligned_out = sum[1];

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            iadder_q_out     <= '0;
            iadder_src_q_out <= 1'b0;
        end else begin
            iadder_q_out     <= iadder_out;
            iadder_src_q_out <= iadder_src_in;
        end
    end

endmodule

// File: tb/tb_msrv32_immediate_adder.sv
// Directed self-checking bench for msrv32_immediate_adder.
module tb_msrv32_immediate_adder;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] rs1_in;
    logic [31:0] imm_in;
    logic        iadder_src_in;
    logic [31:0] iadder_out;
    logic [31:0] iadder_q_out;
    logic        iadder_src_q_out;
    logic        misaligned_out;

    int errors = 0;
    int checks = 0;

    msrv32_immediate_adder dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .pc_in                (pc_in),
        .rs1_in               (rs1_in),
        .imm_in               (imm_in),
        .iadder_src_in        (iadder_src_in),
        .iadder_out           (iadder_out),
        .iadder_q_out         (iadder_q_out),
        .iadder_src_q_out     (iadder_src_q_out),
        .misaligned_out       (misaligned_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic src);
        @(negedge clk);
        pc_in = pc;
        rs1_in = rs1;
        imm_in = imm;
        iadder_src_in = src;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pc_in = 32'h0000_0040;
        rs1_in = 32'h0;
        imm_in = 32'h0000_0004;
        iadder_src_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (iadder_q_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_q: got %h expected %h", iadder_q_out, 32'h0);
        end
        checks++;
        if (iadder_src_q_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_src_q: got %b expected %b", iadder_src_q_out, 1'b0);
        end
        checks++;
        if (iadder_out !== 32'h0000_0004) begin
            errors++;
            $display("FAIL reset_comb: got %h expected %h", iadder_out, 32'h0000_0004);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pc_add;
        drive(32'h1234_5678, 32'h0, 32'hABCD_EF01, 1'b0);
        checks++;
        if (iadder_out !== 32'hBE02_4579) begin
            errors++;
            $display("FAIL pc_add_comb: got %h expected %h", iadder_out, 32'hBE02_4579);
        end
        checks++;
        if (misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL pc_add_misaligned: got %b expected %b", misaligned_out, 1'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (iadder_q_out !== 32'hBE02_4579) begin
            errors++;
            $display("FAIL pc_add_q: got %h expected %h", iadder_q_out, 32'hBE02_4579);
        end
        checks++;
        if (iadder_src_q_out !== 1'b0) begin
            errors++;
            $display("FAIL pc_add_src_q: got %b expected %b", iadder_src_q_out, 1'b0);
        end
    endtask

    task automatic test_carry_discard;
        logic [31:0] exp;
`ifdef MSRV32_IADDER_JALR_LSB_CLR_EN
        exp = 32'h1FDB_9752;
`else
        exp = 32'h1FDB_9753;
`endif
        drive(32'h0000_0000, 32'h8765_4321, 32'h9876_5432, 1'b1);
        checks++;
        if (iadder_out !== exp) begin
            errors++;
            $display("FAIL carry_comb: got %h expected %h", iadder_out, exp);
        end
        checks++;
        if (misaligned_out !== 1'b1) begin
            errors++;
            $display("FAIL carry_misaligned: got %b expected %b", misaligned_out, 1'b1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (iadder_q_out !== exp) begin
            errors++;
            $display("FAIL carry_q: got %h expected %h", iadder_q_out, exp);
        end
    endtask

    task automatic test_wrap;
        drive(32'hFFFF_FFFC, 32'h5555_5555, 32'h0000_0008, 1'b0);
        checks++;
        if (iadder_out !== 32'h0000_0004) begin
            errors++;
            $display("FAIL wrap_comb: got %h expected %h", iadder_out, 32'h0000_0004);
        end
        checks++;
        if (misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL wrap_misaligned: got %b expected %b", misaligned_out, 1'b0);
        end
    endtask

    task automatic test_negative_imm;
        drive(32'h0000_1000, 32'h0, 32'hFFFF_FFFE, 1'b0);
        checks++;
        if (iadder_out !== 32'h0000_0FFE) begin
            errors++;
            $display("FAIL neg_imm_comb: got %h expected %h", iadder_out, 32'h0000_0FFE);
        end
        checks++;
        if (misaligned_out !== 1'b1) begin
            errors++;
            $display("FAIL neg_imm_misaligned: got %b expected %b", misaligned_out, 1'b1);
        end
    endtask

    task automatic test_reset_midrun;
        drive(32'h0000_0000, 32'h0000_0100, 32'h0000_0020, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (iadder_q_out !== 32'h0000_0120 || iadder_src_q_out !== 1'b1) begin
            errors++;
            $display("FAIL midrun_preload: got %h/%b expected %h/%b",
                     iadder_q_out, iadder_src_q_out, 32'h0000_0120, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (iadder_q_out !== 32'h0 || iadder_src_q_out !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async_clear: got %h/%b expected %h/%b",
                     iadder_q_out, iadder_src_q_out, 32'h0, 1'b0);
        end
        checks++;
        if (iadder_out !== 32'h0000_0120) begin
            errors++;
            $display("FAIL midrun_comb_in_reset: got %h expected %h", iadder_out, 32'h0000_0120);
        end
        drive(32'h0000_0200, 32'h0000_0100, 32'h0000_0030, 1'b0);
        checks++;
        if (iadder_out !== 32'h0000_0230) begin
            errors++;
            $display("FAIL midrun_comb_track: got %h expected %h", iadder_out, 32'h0000_0230);
        end
        @(posedge clk);
        #1;
        checks++;
        if (iadder_q_out !== 32'h0) begin
            errors++;
            $display("FAIL midrun_held: got %h expected %h", iadder_q_out, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (iadder_q_out !== 32'h0000_0230 || iadder_src_q_out !== 1'b0) begin
            errors++;
            $display("FAIL midrun_first_capture: got %h/%b expected %h/%b",
                     iadder_q_out, iadder_src_q_out, 32'h0000_0230, 1'b0);
        end
    endtask

    task automatic test_src_toggle;
        drive(32'h0000_0100, 32'h0000_2000, 32'h0000_0010, 1'b0);
        checks++;
        if (iadder_out !== 32'h0000_0110) begin
            errors++;
            $display("FAIL toggle_pc_comb: got %h expected %h", iadder_out, 32'h0000_0110);
        end
        @(posedge clk);
        #1;
        drive(32'h0000_0100, 32'h0000_2000, 32'h0000_0010, 1'b1);
        checks++;
        if (iadder_out !== 32'h0000_2010) begin
            errors++;
            $display("FAIL toggle_rs1_comb: got %h expected %h", iadder_out, 32'h0000_2010);
        end
        checks++;
        if (iadder_src_q_out !== 1'b0) begin
            errors++;
            $display("FAIL toggle_src_q_lag: got %b expected %b", iadder_src_q_out, 1'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (iadder_src_q_out !== 1'b1 || iadder_q_out !== 32'h0000_2010) begin
            errors++;
            $display("FAIL toggle_src_q_follow: got %b/%h expected %b/%h",
                     iadder_src_q_out, iadder_q_out, 1'b1, 32'h0000_2010);
        end
        drive(32'h0000_0100, 32'h0000_2000, 32'h0000_0010, 1'b0);
        checks++;
        if (iadder_out !== 32'h0000_0110 || iadder_src_q_out !== 1'b1) begin
            errors++;
            $display("FAIL toggle_back: got %h/%b expected %h/%b",
                     iadder_out, iadder_src_q_out, 32'h0000_0110, 1'b1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (iadder_src_q_out !== 1'b0 || iadder_q_out !== 32'h0000_0110) begin
            errors++;
            $display("FAIL toggle_back_q: got %b/%h expected %b/%h",
                     iadder_src_q_out, iadder_q_out, 1'b0, 32'h0000_0110);
        end
    endtask

    initial begin
        test_reset;
        test_pc_add;
        test_carry_discard;
        test_wrap;
        test_negative_imm;
        test_reset_midrun;
        test_src_toggle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
